// File: rtl/seg7_pkg.sv
// ============================================================================
// Module : seg7_pkg
// Brief  : Shared types and constants for the 7-segment scan controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package seg7_pkg;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    typedef logic [3:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } conv_state_t;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] v;
        v = 64'd1;
        for (int i = 0; i < n; i++) begin
            v = v * 64'd10;
        end
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/seg7_scan_ctrl_if.sv
// ============================================================================
// Module : seg7_scan_ctrl_if
// Brief  : Load handshake and multiplexed display bus of seg7_scan_ctrl.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface seg7_scan_ctrl_if #(
    parameter int NDIG  = 4,
    parameter int BIN_W = 14
);
    logic             iLOAD;
    logic [BIN_W-1:0] iBIN;
    logic             oBUSY;
    logic             oOVF;
    logic [3:0]       oDIGIT;
    logic [NDIG-1:0]  oDIG_SEL;

    modport master (
        output iLOAD, iBIN,
        input  oBUSY, oOVF, oDIGIT, oDIG_SEL
    );

    modport slave (
        input  iLOAD, iBIN,
        output oBUSY, oOVF, oDIGIT, oDIG_SEL
    );
endinterface

`default_nettype wire

// File: rtl/seg7_scan_ctrl_bin2bcd_seq.sv
// ============================================================================
// Module : bin2bcd_seq
// Brief  : Load handshake plus sequential double-dabble binary-to-BCD converter.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bin2bcd_seq
    import seg7_pkg::*;
#(
    parameter int NDIG  = 4,
    parameter int BIN_W = 14
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              i_load,
    input  wire logic [BIN_W-1:0]  i_bin,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_ovf,
    output logic [NDIG*4-1:0]      o_bcd
);

    localparam int          CNT_W     = $clog2(BIN_W + 1);
    localparam logic [63:0] c_MAX_VAL = pow10(NDIG) - 64'd1;

    conv_state_t        r_state;
    conv_state_t        w_state_nxt;
    logic [BIN_W-1:0]   r_bin;
    logic [NDIG*4-1:0]  r_bcd;
    logic [NDIG*4-1:0]  w_adj;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (i_load) w_state_nxt = SHIFT;
            SHIFT:   if (r_cnt == CNT_W'(BIN_W - 1)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NDIG; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5) begin
                w_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_bin <= '0;
            r_bcd <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_load) begin
                        r_bin <= i_bin;
                        r_bcd <= '0;
                        r_cnt <= '0;
                        r_ovf <= (64'(i_bin) > c_MAX_VAL);
                    end
                end
                SHIFT: begin
                    // A carry out of the top digit can only happen on an overflowed value.
                    r_bcd <= {w_adj[NDIG*4-2:0], r_bin[BIN_W-1]};
                    r_bin <= {r_bin[BIN_W-2:0], 1'b0};
                    r_cnt <= r_cnt + 1'b1;
                    r_ovf <= r_ovf | w_adj[NDIG*4-1];
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != IDLE);
    assign o_done = (r_state == DONE);
    assign o_ovf  = r_ovf;
    assign o_bcd  = r_bcd;

endmodule

`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
// ============================================================================
// Module : seg7_scan_ctrl
// Brief  : BCD conversion, display registers and digit scan for a muxed display.
//          Option macro LEADING_ZERO_BLANK_EN blanks leading zero digits.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int NDIG     = 4,
    parameter int BIN_W    = 14,
    parameter int SCAN_DIV = 50000
) (
    input wire logic         iCLK,
    input wire logic         iRST,
    seg7_scan_ctrl_if.slave  bus
);

    localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int PRE_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    function automatic logic [NDIG*4-1:0] f_disp_rst();
        logic [NDIG*4-1:0] v;
        v = '0;
`ifdef LEADING_ZERO_BLANK_EN
        for (int i = 1; i < NDIG; i++) begin
            v[i*4 +: 4] = BCD_BLANK;
        end
`endif
        return v;
    endfunction

    localparam logic [NDIG*4-1:0] c_DISP_RST = f_disp_rst();

    logic               w_busy;
    logic               w_done;
    logic               w_ovf;
    logic [NDIG*4-1:0]  w_bcd;
    logic [NDIG*4-1:0]  w_disp_nxt;
    logic [NDIG*4-1:0]  r_disp;
    logic               r_ovf;
    logic [PRE_W-1:0]   r_pre;
    logic [IDX_W-1:0]   r_idx;
    logic               w_pre_tc;
    bcd_t               r_digit;
    logic [NDIG-1:0]    r_sel;

    bin2bcd_seq #(
        .NDIG  (NDIG),
        .BIN_W (BIN_W)
    ) u_conv (
        .clk    (iCLK),
        .rst    (iRST),
        .i_load (bus.iLOAD),
        .i_bin  (bus.iBIN),
        .o_busy (w_busy),
        .o_done (w_done),
        .o_ovf  (w_ovf),
        .o_bcd  (w_bcd)
    );

    always_comb begin
`ifdef LEADING_ZERO_BLANK_EN
        logic w_lead;
        w_lead = 1'b1;
`endif
        w_disp_nxt = w_bcd;
`ifdef LEADING_ZERO_BLANK_EN
        // Digit 0 is excluded so that a value of zero still shows "0".
        for (int i = NDIG - 1; i > 0; i--) begin
            if (w_lead && (w_bcd[i*4 +: 4] == 4'h0)) begin
                w_disp_nxt[i*4 +: 4] = BCD_BLANK;
            end else begin
                w_lead = 1'b0;
            end
        end
`endif
        if (w_ovf) begin
            w_disp_nxt = {NDIG{BCD_BLANK}};
        end
    end

    assign w_pre_tc = (r_pre == PRE_W'(SCAN_DIV - 1));

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_disp  <= c_DISP_RST;
            r_ovf   <= 1'b0;
            r_pre   <= '0;
            r_idx   <= '0;
            r_digit <= 4'h0;
            r_sel   <= ~NDIG'(1);
        end else begin
            if (w_done) begin
                r_disp <= w_disp_nxt;
                r_ovf  <= w_ovf;
            end
            r_pre <= w_pre_tc ? '0 : r_pre + 1'b1;
            if (w_pre_tc) begin
                r_idx <= (r_idx == IDX_W'(NDIG - 1)) ? '0 : r_idx + 1'b1;
            end
            // Select and nibble follow the index together, one cycle behind it.
            r_digit <= r_disp[r_idx*4 +: 4];
            r_sel   <= ~(NDIG'(1) << r_idx);
        end
    end

    assign bus.oBUSY    = w_busy;
    assign bus.oOVF     = r_ovf;
    assign bus.oDIGIT   = r_digit;
    assign bus.oDIG_SEL = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_seg7_scan_ctrl.sv
// ============================================================================
// Module : tb_seg7_scan_ctrl
// Brief  : Directed scoreboard bench for seg7_scan_ctrl (NDIG=4, SCAN_DIV=4).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_seg7_scan_ctrl;
    import seg7_pkg::*;

    logic iCLK = 1'b0;
    logic iRST;
    int   n_checks = 0;
    int   n_errors = 0;
    bcd_t exp_dig_q[$];
    logic exp_ovf_q[$];

    seg7_scan_ctrl_if #(.NDIG(4), .BIN_W(14)) bus ();

    seg7_scan_ctrl #(
        .NDIG     (4),
        .BIN_W    (14),
        .SCAN_DIV (4)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    always #5 iCLK = ~iCLK;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bcd_t exp_digit(input int v, input int k);
        int p;
        p = 1;
        for (int j = 0; j < k; j++) p = p * 10;
        if (v > 9999) return 4'hF;
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && v < p) return 4'hF;
`endif
        return bcd_t'((v / p) % 10);
    endfunction

    task automatic push_expect(input int v);
        for (int k = 0; k < 4; k++) exp_dig_q.push_back(exp_digit(v, k));
        exp_ovf_q.push_back(v > 9999);
    endtask

    task automatic wait_sel(input int k);
        int n;
        logic [3:0] s;
        s = ~(4'b0001 << k);
        n = 0;
        while (bus.oDIG_SEL !== s && n < 40) begin
            tick();
            n++;
        end
        chk("sel_wait_in_time", 32'(n < 40), 32'd1);
    endtask

    task automatic count_busy(output int n);
        n = 0;
        while (bus.oBUSY === 1'b1 && n < 60) begin
            tick();
            n++;
        end
    endtask

    task automatic do_load(input int v, input bit push);
        bus.iLOAD = 1'b1;
        bus.iBIN  = 14'(v);
        if (push) push_expect(v);
        tick();
        bus.iLOAD = 1'b0;
    endtask

    task automatic read_display(input string tag);
        bcd_t d;
        logic o;
        tick();
        tick();
        for (int k = 0; k < 4; k++) begin
            wait_sel(k);
            d = exp_dig_q.pop_front();
            chk($sformatf("%s_digit%0d", tag, k), 32'(bus.oDIGIT), 32'(d));
        end
        o = exp_ovf_q.pop_front();
        chk({tag, "_ovf"}, 32'(bus.oOVF), 32'(o));
    endtask

    initial begin
        int n;
        logic [3:0] s;

        iRST      = 1'b1;
        bus.iLOAD = 1'b0;
        bus.iBIN  = '0;
        #1;
        chk("rst_busy", 32'(bus.oBUSY), 32'd0);
        chk("rst_ovf", 32'(bus.oOVF), 32'd0);
        chk("rst_sel", 32'(bus.oDIG_SEL), 32'hE);
        chk("rst_digit", 32'(bus.oDIGIT), 32'h0);
        tick();
        tick();
        iRST = 1'b0;

        // Scan rotation: each select held exactly four clocks
        n = 0;
        while (bus.oDIG_SEL !== 4'b1101 && n < 20) begin
            tick();
            n++;
        end
        chk("scan_first_step", 32'(n < 20), 32'd1);
        for (int k = 0; k < 12; k++) begin
            s = ~(4'b0001 << ((1 + k / 4) % 4));
            chk($sformatf("scan_sel_c%0d", k), 32'(bus.oDIG_SEL), 32'(s));
            tick();
        end
        wait_sel(0);
        chk("idle_digit0", 32'(bus.oDIGIT), 32'h0);

        // Basic conversion and busy length
        do_load(1234, 1'b1);
        count_busy(n);
        chk("busy_len_1234", 32'(n), 32'd15);
        read_display("v1234");

        do_load(9999, 1'b1);
        count_busy(n);
        chk("busy_len_9999", 32'(n), 32'd15);
        read_display("v9999");

        do_load(10000, 1'b1);
        count_busy(n);
        chk("busy_len_10000", 32'(n), 32'd15);
        read_display("v10000");

        // Load strobe during conversion is dropped
        do_load(42, 1'b1);
        tick();
        tick();
        chk("busy_mid_42", 32'(bus.oBUSY), 32'd1);
        bus.iLOAD = 1'b1;
        bus.iBIN  = 14'(5678);
        tick();
        bus.iLOAD = 1'b0;
        count_busy(n);
        chk("busy_len_42", 32'(n + 3), 32'd15);
        read_display("v42");
        chk("no_requeue_busy", 32'(bus.oBUSY), 32'd0);

        // Overflow then async reset mid-conversion
        do_load(10000, 1'b1);
        count_busy(n);
        read_display("v10000b");
        do_load(777, 1'b0);
        for (int k = 0; k < 4; k++) tick();
        chk("busy_mid_777", 32'(bus.oBUSY), 32'd1);
        iRST = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.oBUSY), 32'd0);
        chk("arst_sel", 32'(bus.oDIG_SEL), 32'hE);
        chk("arst_digit", 32'(bus.oDIGIT), 32'h0);
        chk("arst_ovf", 32'(bus.oOVF), 32'd0);
        tick();
        iRST = 1'b0;
        push_expect(0);
        read_display("after_rst");

        // Small values exercise leading-digit handling
        do_load(7, 1'b1);
        count_busy(n);
        read_display("v7");
        do_load(0, 1'b1);
        count_busy(n);
        read_display("v0");
        do_load(105, 1'b1);
        count_busy(n);
        read_display("v105");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
